sobel_frame_sequencer: RTL

- Frame-level controller for the Sobel filter.
- On start, feeds exactly IMG_W*IMG_H RGB pixels from a source stream into the filter's 24-bit input channel.
- Joins the filter's three independent 8-bit result channels (R, G, B) back into one 24-bit pixel stream with end-of-line and end-of-frame markers.
- Sits between the frame buffer/DMA stream and the filter; pulses done once the last result has been delivered.

---
 rtl/sobel_frame_sequencer.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_sequencer.sv
// ============================================================================
// sobel_frame_sequencer
//
// Frame-level controller that sits between the frame buffer / DMA stream and
// the Sobel filter. On a start request it passes exactly IMG_W*IMG_H source
// pixels into the filter's 24-bit input channel. It then rejoins the filter's
// three independent 8-bit result channels into one 24-bit pixel stream that
// carries end-of-line and end-of-frame markers. A one-cycle done pulse follows
// the delivery of the last joined pixel.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_start              start one frame (only honoured in IDLE)
//   o_busy, o_done       frame in progress / one-cycle completion pulse
//   i_src_*, o_src_busy  source pixel stream (vld/busy handshake)
//   o_rgb_*, i_rgb_busy  filter input channel
//   i_new{R,G,B}_*       filter result channels, one byte each
//   o_new{R,G,B}_busy    per-channel result backpressure
//   o_pix_*, i_pix_busy  joined output stream with eol/last markers
//
// Every channel uses the same handshake: a transfer happens on a cycle with
// vld=1 and busy=0.
// ============================================================================
module sobel_frame_sequencer #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int CW    = 17
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,

    input  logic        i_src_vld,
    input  logic [23:0] i_src_data,
    output logic        o_src_busy,

    output logic        o_rgb_vld,
    output logic [23:0] o_rgb_data,
    input  logic        i_rgb_busy,

    input  logic        i_newR_vld,
    input  logic [7:0]  i_newR_data,
    output logic        o_newR_busy,
    input  logic        i_newG_vld,
    input  logic [7:0]  i_newG_data,
    output logic        o_newG_busy,
    input  logic        i_newB_vld,
    input  logic [7:0]  i_newB_data,
    output logic        o_newB_busy,

    output logic        o_pix_vld,
    output logic [23:0] o_pix_data,
    output logic        o_pix_eol,
    output logic        o_pix_last,
    input  logic        i_pix_busy
);

    // Frame geometry expressed in counter width so every compare is CW bits.
    localparam int            NPIX     = IMG_W * IMG_H;
    localparam logic [CW-1:0] N_PIX    = CW'(NPIX);
    localparam logic [CW-1:0] N_LAST   = CW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [CW-1:0] r_inCnt;
    logic [CW-1:0] r_outCnt;
    logic [CW-1:0] r_col;

    logic [7:0]    r_holdR;
    logic [7:0]    r_holdG;
    logic [7:0]    r_holdB;
    logic          r_fullR;
    logic          r_fullG;
    logic          r_fullB;

    logic          r_pixVld;
    logic [23:0]   r_pixData;
    logic          r_pixEol;
    logic          r_pixLast;

    logic          w_feedEn;
    logic          w_inXfer;
    logic          w_outXfer;
    logic          w_joinOpen;
    logic          w_newRBusy;
    logic          w_newGBusy;
    logic          w_newBBusy;
    logic          w_capR;
    logic          w_capG;
    logic          w_capB;
    logic          w_allFull;
    logic          w_startAccept;
    logic          w_lastOut;

    // ------------------------------------------------------------------------
    // Handshake decodes shared by the FSM, counters and join path.
    // ------------------------------------------------------------------------
    assign w_startAccept = (r_state == IDLE) && i_start;

    // Feed path is a pure pass-through: the source stream is gated off
    // outside RUN and once the whole frame has been handed to the filter.
    assign w_feedEn   = (r_state == RUN) && (r_inCnt < N_PIX);
    assign o_rgb_vld  = w_feedEn && i_src_vld;
    assign o_rgb_data = i_src_data;
    assign o_src_busy = !w_feedEn || i_rgb_busy;
    assign w_inXfer   = o_rgb_vld && !i_rgb_busy;

    assign w_outXfer  = r_pixVld && !i_pix_busy;
    assign w_lastOut  = w_outXfer && (r_outCnt == N_LAST);

    // Results arriving outside a frame are held off rather than captured,
    // so a filter that is still flushing cannot leak into the next frame.
    assign w_joinOpen = (r_state == RUN) || (r_state == DRAIN);
    assign w_newRBusy = r_fullR || !w_joinOpen;
    assign w_newGBusy = r_fullG || !w_joinOpen;
    assign w_newBBusy = r_fullB || !w_joinOpen;

    assign o_newR_busy = w_newRBusy;
    assign o_newG_busy = w_newGBusy;
    assign o_newB_busy = w_newBBusy;

    assign w_capR    = i_newR_vld && !w_newRBusy;
    assign w_capG    = i_newG_vld && !w_newGBusy;
    assign w_capB    = i_newB_vld && !w_newBBusy;
    assign w_allFull = r_fullR && r_fullG && r_fullB;

    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_pix_vld  = r_pixVld;
    assign o_pix_data = r_pixData;
    assign o_pix_eol  = r_pixEol;
    assign o_pix_last = r_pixLast;

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. When the final input and the final output land in
    // the same cycle there is nothing left to drain, so RUN goes straight to
    // DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_inXfer && (r_inCnt == N_LAST)) begin
                    w_nextState = w_lastOut ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastOut) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame counters. A start clears them; no transfer can happen in IDLE, so
    // the clear never competes with an increment.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inCnt  <= '0;
            r_outCnt <= '0;
            r_col    <= '0;
        end else if (w_startAccept) begin
            r_inCnt  <= '0;
            r_outCnt <= '0;
            r_col    <= '0;
        end else begin
            if (w_inXfer) begin
                r_inCnt <= r_inCnt + ONE;
            end
            if (w_outXfer) begin
                r_outCnt <= r_outCnt + ONE;
                r_col    <= (r_col == COL_LAST) ? '0 : (r_col + ONE);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel holding registers. Each channel captures one byte and then
    // stalls until the joined pixel has left; an output transfer can only
    // happen while all three are full, so release and capture never overlap.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_holdR <= '0;
            r_holdG <= '0;
            r_holdB <= '0;
            r_fullR <= 1'b0;
            r_fullG <= 1'b0;
            r_fullB <= 1'b0;
        end else if (w_outXfer) begin
            r_fullR <= 1'b0;
            r_fullG <= 1'b0;
            r_fullB <= 1'b0;
        end else begin
            if (w_capR) begin
                r_holdR <= i_newR_data;
                r_fullR <= 1'b1;
            end
            if (w_capG) begin
                r_holdG <= i_newG_data;
                r_fullG <= 1'b1;
            end
            if (w_capB) begin
                r_holdB <= i_newB_data;
                r_fullB <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register. It loads once all channels hold a byte and keeps the
    // pixel and its markers stable until the sink takes it. The markers come
    // from the column and output counters, which at load time describe the
    // pixel being loaded.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pixVld  <= 1'b0;
            r_pixData <= '0;
            r_pixEol  <= 1'b0;
            r_pixLast <= 1'b0;
        end else if (w_outXfer) begin
            r_pixVld <= 1'b0;
        end else if (w_allFull && !r_pixVld) begin
            r_pixVld  <= 1'b1;
            r_pixData <= {r_holdR, r_holdG, r_holdB};
            r_pixEol  <= (r_col == COL_LAST);
            r_pixLast <= (r_outCnt == N_LAST);
        end
    end

endmodule
